approx_mult_seq_ctrl: RTL

Parametrised sequencing controller for the approximate-multiplier pipeline. It walks a programmable number of operand pairs from the input RAM and normalises both operands in parallel. It then triggers a KEEP_W×KEEP_W multiply of the leading bits, denormalises the product left or right, and writes it to the output RAM under a ready handshake. The block drives the shared datapath (operand shift registers, multiplier, result shifter) and owns every counter: pair address, per-operand shift counts and result shift count.

---
 rtl/approx_mult_seq_ctrl_pkg.sv | 35 +++
 rtl/approx_mult_seq_ctrl_norm.sv | 41 ++++
 rtl/approx_mult_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_seq_ctrl_pkg.sv
// Shared definitions for the approximate-multiplier sequencing controller:
// state encoding, a constant-foldable clog2 and the default datapath widths.
package approx_mult_seq_ctrl_pkg;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Controller states; IDLE is zero so the reset state reads as all-zero.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LD   = 3'd2,
        ST_NORM = 3'd3,
        ST_MUL  = 3'd4,
        ST_ADJ  = 3'd5,
        ST_WR   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    // Datapath widths for the default 16-bit operand configuration.
    localparam int DEF_DATA_W = 16;
    localparam int SHIFT_CW   = clog2(DEF_DATA_W);
    localparam int RES_CW     = clog2(2 * DEF_DATA_W) + 1;

endpackage

// File: rtl/approx_mult_seq_ctrl_norm.sv
// norm_shift_cnt: leading-zero normaliser control for one operand.
// Requests a left shift while the operand MSB is clear, counting shifts and
// saturating at DATA_W-1 so an all-zero operand terminates and flags zero.
module norm_shift_cnt
    import approx_mult_seq_ctrl_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int CW     = clog2(DATA_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          msb,
    output logic          sh,
    output logic          done,
    output logic          zero,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

    logic at_max;

    assign at_max = (cnt == CNT_MAX);
    assign sh     = en && !msb && !at_max;
    assign done   = msb || at_max;
    assign zero   = !msb && at_max;

    // Shift counter: cleared before each operand load, steps with every shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sh) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// approx_mult_seq_ctrl: walks N operand pairs through read, normalise,
// KEEP_W x KEEP_W multiply, product denormalise and handshaked write.
// The datapath lives outside; this block only issues strobes and owns the
// pair index, pair count, per-operand shift counts and result shift count.
//
// Write handshake: wr_en acts as valid. Once raised in WR, wr_en and wr_addr
// stay constant until a cycle with wr_ready also high; the write transfers on
// that clock edge and the controller moves on in the same edge.
module approx_mult_seq_ctrl
    import approx_mult_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int KEEP_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_pairs,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              ld_ab,
    input  logic              msb_a,
    input  logic              msb_b,
    output logic              sh_a,
    output logic              sh_b,
    output logic              mul_en,
    output logic              res_clr,
    output logic              res_shl,
    output logic              res_shr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic [2:0]        dbg_state
);

    localparam int CW   = clog2(DATA_W);
    localparam int RCW  = clog2(2 * DATA_W) + 1;
    // Shift total at which the KEEP_W x KEEP_W product already sits at the
    // weight of the full DATA_W x DATA_W product.
    localparam int BIAS = 2 * (DATA_W - KEEP_W);
    localparam logic [ADDR_W:0] NMAX = {1'b1, {ADDR_W{1'b0}}};

    state_t state, state_nxt;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   n_pairs;
    logic [RCW-1:0]    res_cnt;
    logic              shr_dir;

    logic              cnt_clr;
    logic              norm_en;
    logic              done_a, done_b;
    logic              zero_a, zero_b;
    logic              zero_any;
    logic [CW-1:0]     cnt_a, cnt_b;
    logic signed [RCW-1:0] diff;
    logic [RCW-1:0]    diff_abs;
    logic              is_last;

    assign cnt_clr  = (state == ST_IDLE) || (state == ST_LD);
    assign norm_en  = (state == ST_NORM);
    assign zero_any = zero_a || zero_b;
    assign diff     = $signed(RCW'(cnt_a)) + $signed(RCW'(cnt_b)) - $signed(RCW'(BIAS));
    assign diff_abs = diff[RCW-1] ? (~diff + 1'b1) : diff;
    assign is_last  = ({1'b0, idx} == (n_pairs - 1'b1));
    assign dbg_state = state;

    norm_shift_cnt #(.DATA_W(DATA_W)) u_norm_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (norm_en),
        .msb  (msb_a),
        .sh   (sh_a),
        .done (done_a),
        .zero (zero_a),
        .cnt  (cnt_a)
    );

    norm_shift_cnt #(.DATA_W(DATA_W)) u_norm_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (norm_en),
        .msb  (msb_b),
        .sh   (sh_b),
        .done (done_b),
        .zero (zero_b),
        .cnt  (cnt_b)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pair index, latched pair count and result shift bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            n_pairs <= '0;
            res_cnt <= '0;
            shr_dir <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (start) begin
                        n_pairs <= (num_pairs == '0) ? NMAX : num_pairs;
                    end
                end
                ST_MUL: begin
                    if (!zero_any) begin
                        res_cnt <= diff_abs;
                        shr_dir <= !diff[RCW-1];
                    end
                end
                ST_ADJ: begin
                    res_cnt <= res_cnt - 1'b1;
                end
                ST_WR: begin
                    if (wr_ready && !is_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and strobe decode; at most one datapath strobe per state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        ld_ab     = 1'b0;
        mul_en    = 1'b0;
        res_clr   = 1'b0;
        res_shl   = 1'b0;
        res_shr   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RD;
            end
            ST_RD: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                rd_addr   = idx;
                state_nxt = ST_LD;
            end
            ST_LD: begin
                busy      = 1'b1;
                ld_ab     = 1'b1;
                state_nxt = ST_NORM;
            end
            ST_NORM: begin
                busy = 1'b1;
                if (done_a && done_b) state_nxt = ST_MUL;
            end
            ST_MUL: begin
                busy = 1'b1;
                if (zero_any) begin
                    res_clr   = 1'b1;
                    state_nxt = ST_WR;
                end else begin
                    mul_en    = 1'b1;
                    state_nxt = (diff == '0) ? ST_WR : ST_ADJ;
                end
            end
            ST_ADJ: begin
                busy = 1'b1;
                if (shr_dir) res_shr = 1'b1;
                else         res_shl = 1'b1;
                if (res_cnt == RCW'(1)) state_nxt = ST_WR;
            end
            ST_WR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = idx;
                if (wr_ready) state_nxt = is_last ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
